// File: rtl/mult_pipeline_pkg.sv
// Shared defaults for the multiplier pipeline and its result collector.
// DEF_N / DEF_M   : multiplicand / multiplier widths of the pipeline stages
// DEF_DEPTH       : collector FIFO entries (power of two, >= 2)
// DEF_TAG_W       : sequence tag width
// DEF_W, DEF_LVL_W: derived product width and occupancy counter width
package mult_pipeline_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_M     = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TAG_W = 8;

    localparam int DEF_W     = DEF_N + DEF_M;
    localparam int DEF_LVL_W = $clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/mult_result_fifo.sv
// Storage for the result collector: DEPTH-entry array, wrapping read/write
// pointers, a separate up/down occupancy counter and a registered head.
// Ports:
//   clk, rstn   : clock, async active-low reset
//   push, pop   : qualified by the caller (never push when full without pop,
//                 never pop when empty)
//   wdata       : entry to store on push
//   head        : registered head entry, 0 whenever the FIFO is empty
//   level       : current occupancy, 0..DEPTH
module mult_result_fifo
    import mult_pipeline_pkg::*;
#(
    parameter int DW    = DEF_W + DEF_TAG_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DW-1:0]    head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // The head register must show the entry that will sit at rd_ptr after
        // this edge. If that slot is being written this same cycle (empty, or
        // one entry being popped while a new one arrives) the array does not
        // hold it yet, so bypass wdata into the head register.
        if (level_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wdata;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // Array contents are don't-care after reset; head_q masks them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = head_q;
    assign level = level_q;

endmodule

// File: rtl/mult_result_collector.sv
// Collects products from the final multiplier stage into a small FIFO,
// tagging each arrival with a sequence number so downstream can spot drops.
// Ports:
//   clk, rstn          : clock, async active-low reset
//   in_rdy, in_result  : product strobe and value from the final stage
//   out_valid/ready    : head handshake to the consumer
//   out_data, out_tag  : registered head product and its sequence tag
//   level              : occupancy, 0..DEPTH
//   overflow, clr_ovf  : sticky drop flag and its synchronous clear
module mult_result_collector
    import mult_pipeline_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_rdy,
    input  logic [N+M-1:0]         in_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N+M-1:0]         out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int W     = N + M;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int DW    = W + TAG_W;

    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, drop;
    logic [DW-1:0]    head;
    logic [LVL_W-1:0] fifo_level;

    assign out_valid = (fifo_level != '0);
    assign full      = (fifo_level == LVL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = in_rdy && (!full || pop);
    assign drop      = in_rdy && full && !pop;

    always_comb begin
        tag_cnt_d  = tag_cnt_q;
        overflow_d = overflow_q;

        // Dropped arrivals still consume a tag so the gap is visible downstream.
        if (in_rdy) tag_cnt_d = tag_cnt_q + TAG_W'(1);

        // Set has priority over clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            tag_cnt_q  <= tag_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    mult_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata ({in_result, tag_cnt_q}),
        .head  (head),
        .level (fifo_level)
    );

    assign out_data = head[DW-1:TAG_W];
    assign out_tag  = head[TAG_W-1:0];
    assign level    = fifo_level;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_result_collector.sv
module tb_mult_result_collector;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_rdy;
    logic [11:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [7:0]  out_tag;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_result_collector dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_rdy    (in_rdy),
        .in_result (in_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn      = 1'b0;
        in_rdy    = 1'b0;
        in_result = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rstn      = 1'b0;
        in_rdy    = 1'b0;
        in_result = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (out_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", out_data); end
        total++; if (out_tag !== 8'h00) begin bad++; $display("FAIL reset_tag got=%h exp=00", out_tag); end
        rstn = 1'b1;
        tick();
        // out_ready with nothing stored must not disturb anything
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL idle_ready_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_ready_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_single;
        do_reset();
        in_rdy    = 1'b1;
        in_result = 12'h02D;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_fallthru got=%b exp=0", out_valid); end
        tick();
        in_rdy = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 12'h02D) begin bad++; $display("FAIL single_data got=%h exp=02d", out_data); end
        total++; if (out_tag !== 8'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", out_tag); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
        tick();
        total++; if (out_data !== 12'h02D) begin bad++; $display("FAIL single_hold got=%h exp=02d", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 12'h000) begin bad++; $display("FAIL single_empty_data got=%h exp=000", out_data); end
    endtask

    task automatic test_overflow;
        logic [2:0] exp_lvl [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_rdy    = 1'b1;
            in_result = 12'(i + 1);
            tick();
            total++; if (level !== exp_lvl[i]) begin bad++; $display("FAIL ovf_fill_level i=%0d got=%0d exp=%0d", i, level, exp_lvl[i]); end
            total++; if (overflow !== exp_ovf[i]) begin bad++; $display("FAIL ovf_fill_flag i=%0d got=%b exp=%b", i, overflow, exp_ovf[i]); end
        end
        in_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== 12'(i + 1)) begin bad++; $display("FAIL ovf_drain_data i=%0d got=%h exp=%h", i, out_data, 12'(i + 1)); end
            total++; if (out_tag !== 8'(i)) begin bad++; $display("FAIL ovf_drain_tag i=%0d got=%0d exp=%0d", i, out_tag, i); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL ovf_drained_level got=%0d exp=0", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop;
        logic [11:0] exp_d [4] = '{12'h011, 12'h012, 12'h013, 12'h099};
        logic [7:0]  exp_t [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_rdy    = 1'b1;
            in_result = 12'h010 + 12'(i);
            tick();
        end
        in_rdy    = 1'b1;
        in_result = 12'h099;
        out_ready = 1'b1;
        tick();
        in_rdy    = 1'b0;
        out_ready = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fullpp_level got=%0d exp=4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL fullpp_data i=%0d got=%h exp=%h", i, out_data, exp_d[i]); end
            total++; if (out_tag !== exp_t[i]) begin bad++; $display("FAIL fullpp_tag i=%0d got=%0d exp=%0d", i, out_tag, exp_t[i]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_clr_ovf;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_rdy    = 1'b1;
            in_result = 12'h0A0 + 12'(i);
            tick();
        end
        in_rdy    = 1'b1;
        in_result = 12'h0FF;
        clr_ovf   = 1'b1;
        tick();
        in_rdy = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_set_wins got=%b exp=1", overflow); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL clr_drop_level got=%0d exp=4", level); end
        total++; if (out_data !== 12'h0A0) begin bad++; $display("FAIL clr_drop_head got=%h exp=0a0", out_data); end
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b exp=0", overflow); end
        // drain, checking the dropped tag (4) is the gap after 3
        for (int i = 0; i < 4; i++) begin
            total++; if (out_tag !== 8'(i)) begin bad++; $display("FAIL clr_drain_tag i=%0d got=%0d exp=%0d", i, out_tag, i); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        in_rdy    = 1'b1;
        in_result = 12'h123;
        tick();
        in_rdy = 1'b0;
        total++; if (out_tag !== 8'd5) begin bad++; $display("FAIL clr_gap_tag got=%0d exp=5", out_tag); end
    endtask

    task automatic test_stream;
        int k = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 301; c++) begin
            in_rdy    = (c < 300);
            in_result = 12'(c);
            if (out_valid === 1'b1) begin
                total++; if (out_tag !== 8'(k)) begin bad++; $display("FAIL stream_tag k=%0d got=%0d exp=%0d", k, out_tag, 8'(k)); end
                total++; if (out_data !== 12'(k)) begin bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, 12'(k)); end
                k++;
            end
            tick();
            total++; if (level > 3'd1) begin bad++; $display("FAIL stream_level c=%0d got=%0d exp<=1", c, level); end
        end
        in_rdy    = 1'b0;
        out_ready = 1'b0;
        total++; if (k !== 300) begin bad++; $display("FAIL stream_count got=%0d exp=300", k); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_rdy    = 1'b1;
            in_result = 12'h050 + 12'(i);
            tick();
        end
        in_rdy = 1'b0;
        total++; if (level !== 3'd3) begin bad++; $display("FAIL mrst_pre_level got=%0d exp=3", level); end
        rstn = 1'b0;
        #1;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL mrst_async_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_async_valid got=%b exp=0", out_valid); end
        tick();
        rstn = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_idle_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 12'h000) begin bad++; $display("FAIL mrst_idle_data got=%h exp=000", out_data); end
        in_rdy    = 1'b1;
        in_result = 12'h0AB;
        tick();
        in_rdy = 1'b0;
        total++; if (out_tag !== 8'd0) begin bad++; $display("FAIL mrst_tag got=%0d exp=0", out_tag); end
        total++; if (out_data !== 12'h0AB) begin bad++; $display("FAIL mrst_data got=%h exp=0ab", out_data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL mrst_level got=%0d exp=1", level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clr_ovf();
        test_stream();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_result_collector.md
MULT_RESULT_COLLECTOR -- requirements
Module: mult_result_collector

Interface
REQ-001 The block SHALL have parameter N, default 8: multiplicand width, matching the pipeline stages.
REQ-002 The block SHALL have parameter M, default 4: multiplier width, matching the pipeline stages; result width W = N+M.
REQ-003 The block SHALL have parameter DEPTH, default 4: FIFO entries, power of two, >= 2.
REQ-004 The block SHALL have parameter TAG_W, default 8: sequence tag width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all logic is posedge clk.
REQ-006 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_rdy, input, 1 bit: the result_rdy output of the final multiplier stage; a product is present this cycle.
REQ-008 The block SHALL have port in_result, input, W bits: the result output of the final multiplier stage.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-011 The block SHALL have port out_data, output, W bits: the head product.
REQ-012 The block SHALL have port out_tag, output, TAG_W bits: the head sequence tag.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a product was dropped.
REQ-015 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-016 Push SHALL occur when in_rdy=1 and (level<DEPTH or pop this cycle); the entry stored is {in_result, tag_cnt}.
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 tag_cnt SHALL increment by 1, modulo 2^TAG_W, on every cycle with in_rdy=1, including dropped arrivals, so that gaps in out_tag expose loss; 2^TAG_W-1 SHALL wrap to 0.
REQ-019 out_valid SHALL be 1 iff level>0; there is no fall-through, so a product written at edge k is visible at out_data after edge k and never in the same cycle it arrives.
REQ-020 out_data and out_tag SHALL come from the registered head entry and be held stable while out_valid=1 and out_ready=0.
REQ-021 Full (level=DEPTH) with in_rdy=1 and no pop: the product SHALL be dropped, storage and level SHALL be unchanged, and overflow SHALL be set at the next edge.
REQ-022 Full with in_rdy=1 and a pop: the push SHALL be accepted, level SHALL stay DEPTH, and there SHALL be no overflow.
REQ-023 Empty with in_rdy=1 and out_ready=1: no pop SHALL occur (out_valid=0), the push SHALL be accepted, and level SHALL become 1.
REQ-024 Simultaneous push and pop at non-full level SHALL leave level unchanged.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap naturally; level SHALL be a separate up/down counter.
REQ-026 clr_ovf=1 SHALL clear overflow at the next edge; if an overflow event occurs in the same cycle, set SHALL win.
REQ-027 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-028 Total latency from final-stage result_rdy to out_valid SHALL be 1 cycle when the FIFO is empty.

Reset
REQ-029 rstn=0 SHALL asynchronously force level=0, out_valid=0, overflow=0, tag_cnt=0, pointers=0, out_data=0 and out_tag=0.
REQ-030 Reset mid-operation SHALL discard all stored entries, with no output activity until after the first push following deassertion.
REQ-031 Storage array contents need not be reset; head outputs SHALL read 0 while empty after reset.

Structure
REQ-032 Package mult_pipeline_pkg SHALL hold the default N, M, DEPTH and TAG_W and the derived W and LVL_W constants.
REQ-033 Storage plus pointers SHALL be one sub-module, mult_result_fifo (synchronous, registered read head); the tag counter, overflow and handshake logic SHALL live in the top.

Verification
REQ-034 Reset, then pulse in_rdy with in_result=12'h02D, out_ready=0 -> next cycle out_valid=1, out_data=12'h02D, out_tag=0, level=1.
REQ-035 5 back-to-back pushes (values 1..5), out_ready=0, DEPTH=4 -> level=4, overflow=1 after the 5th; pops then return 1,2,3,4 with tags 0..3.
REQ-036 Full FIFO, in_rdy=1 with out_ready=1 same cycle -> level stays 4, overflow stays 0, the new entry emerges last.
REQ-037 300 pushes with continuous out_ready=1 -> out_tag sequence 0..255,0..43 with no gaps, level never exceeds 1.
REQ-038 Assert clr_ovf in the same cycle as an overflow drop -> overflow remains 1; clr_ovf alone on the next cycle -> overflow=0.
REQ-039 rstn low for 1 cycle while level=3 -> level=0, out_valid=0, tag restarts at 0 on the next push.
